// File: rtl/cmd_sequencer.sv
// cmd_sequencer: buffers decoded SPI command descriptors in a small FIFO and executes
// each one in order as key read, text read, core run and destination write.
module cmd_sequencer #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       des_valid_out,
  input  logic                       des_valid,
  input  logic [OPCODEW-1:0]         des_opcode,
  input  logic [ADDRW-1:0]           des_key_addr,
  input  logic [ADDRW-1:0]           des_text_addr,
  input  logic [ADDRW-1:0]           des_dest_addr,
  output logic                       des_ready,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [1:0]                 mem_req_type,
  output logic [ADDRW-1:0]           mem_req_addr,
  output logic                       core_start,
  output logic [OPCODEW-1:0]         core_opcode,
  input  logic                       core_done,
  output logic                       cmd_done,
  output logic                       cmd_err,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_KEY  = 3'd1,
    S_RD_TEXT = 3'd2,
    S_START   = 3'd3,
    S_WAIT    = 3'd4,
    S_WR_DEST = 3'd5
  } state_t;

  logic [OPCODEW-1:0] op_mem_r   [DEPTH];
  logic [ADDRW-1:0]   key_mem_r  [DEPTH];
  logic [ADDRW-1:0]   text_mem_r [DEPTH];
  logic [ADDRW-1:0]   dest_mem_r [DEPTH];
  logic [PTRW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNTW-1:0]    count_r;

  state_t             state_r, state_s;
  logic [OPCODEW-1:0] op_r, op_s;
  logic [ADDRW-1:0]   key_r, key_s, text_r, text_s, dest_r, dest_s;
  logic               full_s, empty_s, push_s, pop_s, err_s, done_s, xfer_s;
  logic               req_valid_s, start_s;
  logic [1:0]         req_type_s;
  logic [ADDRW-1:0]   req_addr_s;
  logic [OPCODEW-1:0] core_op_s;
  logic               mem_req_valid_r, core_start_r, cmd_done_r, cmd_err_r;
  logic [1:0]         mem_req_type_r;
  logic [ADDRW-1:0]   mem_req_addr_r;
  logic [OPCODEW-1:0] core_opcode_r;

  assign full_s    = (count_r == CNTW'(DEPTH));
  assign empty_s   = (count_r == {CNTW{1'b0}});
  assign des_ready = !full_s && !rst;
  // A strobe with des_valid=0 is still accepted but never stored.
  assign push_s    = des_valid_out && des_ready && des_valid;
  assign xfer_s    = mem_req_valid_r && mem_req_ready;

  // Descriptor FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
      count_r  <= {CNTW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        op_mem_r[i]   <= {OPCODEW{1'b0}};
        key_mem_r[i]  <= {ADDRW{1'b0}};
        text_mem_r[i] <= {ADDRW{1'b0}};
        dest_mem_r[i] <= {ADDRW{1'b0}};
      end
    end else begin
      if (push_s) begin
        op_mem_r[wr_ptr_r]   <= des_opcode;
        key_mem_r[wr_ptr_r]  <= des_key_addr;
        text_mem_r[wr_ptr_r] <= des_text_addr;
        dest_mem_r[wr_ptr_r] <= des_dest_addr;
        wr_ptr_r             <= wr_ptr_r + PTRW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTRW'(1);
      end
      count_r <= count_r + CNTW'(push_s) - CNTW'(pop_s);
    end
  end

  // Next-state logic, FIFO pop and retirement/error pulses.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    err_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          if (op_mem_r[rd_ptr_r] == {OPCODEW{1'b1}}) begin
            err_s = 1'b1;
          end else begin
            state_s = S_RD_KEY;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD_KEY:  state_s = xfer_s ? S_RD_TEXT : S_RD_KEY;
      S_RD_TEXT: state_s = xfer_s ? S_START : S_RD_TEXT;
      S_START:   state_s = S_WAIT;
      S_WAIT:    state_s = core_done ? S_WR_DEST : S_WAIT;
      S_WR_DEST: begin
        if (xfer_s) begin
          state_s = S_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = S_WR_DEST;
        end
      end
      default:   state_s = S_IDLE;
    endcase
  end

  // Working descriptor and next output values, computed from the next state.
  always_comb begin
    op_s        = op_r;
    key_s       = key_r;
    text_s      = text_r;
    dest_s      = dest_r;
    req_valid_s = 1'b0;
    req_type_s  = 2'd0;
    req_addr_s  = {ADDRW{1'b0}};
    start_s     = 1'b0;
    core_op_s   = {OPCODEW{1'b0}};
    if (pop_s) begin
      op_s   = op_mem_r[rd_ptr_r];
      key_s  = key_mem_r[rd_ptr_r];
      text_s = text_mem_r[rd_ptr_r];
      dest_s = dest_mem_r[rd_ptr_r];
    end else begin
      op_s = op_r;
    end
    case (state_s)
      S_RD_KEY:  begin req_valid_s = 1'b1; req_type_s = 2'd0; req_addr_s = key_s;  end
      S_RD_TEXT: begin req_valid_s = 1'b1; req_type_s = 2'd1; req_addr_s = text_s; end
      S_WR_DEST: begin req_valid_s = 1'b1; req_type_s = 2'd2; req_addr_s = dest_s; end
      S_START:   begin start_s = 1'b1; core_op_s = op_s; end
      S_WAIT:    core_op_s = op_s;
      default:   req_valid_s = 1'b0;
    endcase
  end

  // State, working descriptor and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      op_r            <= {OPCODEW{1'b0}};
      key_r           <= {ADDRW{1'b0}};
      text_r          <= {ADDRW{1'b0}};
      dest_r          <= {ADDRW{1'b0}};
      mem_req_valid_r <= 1'b0;
      mem_req_type_r  <= 2'd0;
      mem_req_addr_r  <= {ADDRW{1'b0}};
      core_start_r    <= 1'b0;
      core_opcode_r   <= {OPCODEW{1'b0}};
      cmd_done_r      <= 1'b0;
      cmd_err_r       <= 1'b0;
    end else begin
      state_r         <= state_s;
      op_r            <= op_s;
      key_r           <= key_s;
      text_r          <= text_s;
      dest_r          <= dest_s;
      mem_req_valid_r <= req_valid_s;
      mem_req_type_r  <= req_type_s;
      mem_req_addr_r  <= req_addr_s;
      core_start_r    <= start_s;
      core_opcode_r   <= core_op_s;
      cmd_done_r      <= done_s;
      cmd_err_r       <= err_s;
    end
  end

  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_type  = mem_req_type_r;
  assign mem_req_addr  = mem_req_addr_r;
  assign core_start    = core_start_r;
  assign core_opcode   = core_opcode_r;
  assign cmd_done      = cmd_done_r;
  assign cmd_err       = cmd_err_r;
  assign fifo_count    = count_r;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: expected memory requests and core opcodes are
// queued as commands are driven and checked as the DUT issues them.
module tb_cmd_sequencer;
  localparam int ADDRW = 24;

  logic             clk = 1'b0;
  logic             rst, des_valid_out, des_valid, mem_req_ready, core_done;
  logic [1:0]       des_opcode;
  logic [ADDRW-1:0] des_key_addr, des_text_addr, des_dest_addr;
  logic             des_ready, mem_req_valid, core_start, cmd_done, cmd_err;
  logic [1:0]       mem_req_type, core_opcode;
  logic [ADDRW-1:0] mem_req_addr;
  logic [2:0]       fifo_count;

  cmd_sequencer #(.ADDRW(ADDRW), .OPCODEW(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .des_valid_out(des_valid_out), .des_valid(des_valid),
    .des_opcode(des_opcode), .des_key_addr(des_key_addr), .des_text_addr(des_text_addr),
    .des_dest_addr(des_dest_addr), .des_ready(des_ready), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_type(mem_req_type), .mem_req_addr(mem_req_addr),
    .core_start(core_start), .core_opcode(core_opcode), .core_done(core_done),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  logic [ADDRW+1:0] exp_q[$];
  logic [1:0]       op_q[$];
  int done_cnt = 0, start_cnt = 0, err_cnt = 0;
  int done_timer = 0, core_delay = 3;
  bit prev_stall = 1'b0, prev_start = 1'b0;
  logic [1:0]       prev_type, last_type = 2'd3;
  logic [ADDRW-1:0] prev_addr;

  // One clock cycle: sample mid-cycle, score outputs, then act as the crypto core.
  task automatic tick();
    logic [ADDRW+1:0] exp_e;
    logic [1:0]       exp_op;
    @(negedge clk);
    if (!rst) begin
      if (prev_stall) begin
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_type !== prev_type || mem_req_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL req_stable: valid=%b type=%0d addr=%h, required valid=1 type=%0d addr=%h",
                   mem_req_valid, mem_req_type, mem_req_addr, prev_type, prev_addr);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL req_unexpected: type=%0d addr=%h, required no request", mem_req_type, mem_req_addr);
        end else begin
          exp_e = exp_q.pop_front();
          if ({mem_req_type, mem_req_addr} !== exp_e) begin
            n_fail++;
            $display("FAIL req_order: type=%0d addr=%h, required type=%0d addr=%h",
                     mem_req_type, mem_req_addr, exp_e[ADDRW+1:ADDRW], exp_e[ADDRW-1:0]);
          end
        end
        last_type = mem_req_type;
      end
      if (core_start) begin
        n_cmp++;
        if (op_q.size() == 0) begin
          n_fail++;
          $display("FAIL core_start_unexpected: opcode=%0d, required no start", core_opcode);
        end else begin
          exp_op = op_q.pop_front();
          if (core_opcode !== exp_op || prev_start) begin
            n_fail++;
            $display("FAIL core_start: opcode=%0d repeat=%b, required opcode=%0d repeat=0",
                     core_opcode, prev_start, exp_op);
          end
        end
        start_cnt++;
        done_timer = core_delay;
      end
      if (cmd_done) begin
        n_cmp++;
        done_cnt++;
        if (last_type !== 2'd2) begin
          n_fail++;
          $display("FAIL cmd_done_order: last request type=%0d, required 2", last_type);
        end
        last_type = 2'd3;
      end
      if (cmd_err) err_cnt++;
    end
    prev_stall = !rst && mem_req_valid && !mem_req_ready;
    prev_type  = mem_req_type;
    prev_addr  = mem_req_addr;
    prev_start = core_start;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) core_done = 1'b1;
    end
  endtask

  task automatic send_cmd(input logic v, input logic [1:0] op, input logic [ADDRW-1:0] k, t, d,
                          input bit accept);
    des_valid_out = 1'b1; des_valid = v; des_opcode = op;
    des_key_addr = k; des_text_addr = t; des_dest_addr = d;
    if (accept && v && op != 2'b11) begin
      exp_q.push_back({2'd0, k});
      exp_q.push_back({2'd1, t});
      exp_q.push_back({2'd2, d});
      op_q.push_back(op);
    end
    tick();
    des_valid_out = 1'b0; des_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({mem_req_valid, core_start, cmd_done, cmd_err, des_ready} !== 5'b0 || fifo_count !== 3'd0 ||
        mem_req_type !== 2'd0 || mem_req_addr !== 24'h0 || core_opcode !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b st=%b dn=%b er=%b rdy=%b cnt=%0d, required all 0",
               mem_req_valid, core_start, cmd_done, cmd_err, des_ready, fifo_count);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (des_ready !== 1'b1 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: des_ready=%b count=%0d, required 1 and 0", des_ready, fifo_count);
    end
  endtask

  task automatic test_single();
    int d0;
    d0 = done_cnt;
    mem_req_ready = 1'b1; core_delay = 3;
    send_cmd(1'b1, 2'd1, 24'h10, 24'h20, 24'h30, 1'b1);
    n_cmp++;
    if (fifo_count !== 3'd1) begin
      n_fail++; $display("FAIL single_count: count=%0d, required 1", fifo_count);
    end
    tick();
    n_cmp++;
    if (mem_req_valid !== 1'b1 || mem_req_type !== 2'd0 || mem_req_addr !== 24'h10) begin
      n_fail++;
      $display("FAIL single_latency: valid=%b type=%0d addr=%h, required 1 0 000010",
               mem_req_valid, mem_req_type, mem_req_addr);
    end
    for (int i = 0; i < 100 && !(exp_q.size() == 0 && done_cnt == d0 + 1); i++) tick();
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (done_cnt !== d0 + 1 || exp_q.size() != 0 || op_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_retire: cmd_done=%0d pending=%0d, required 1 and 0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [2:0] exp_cnt[5] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
    d0 = done_cnt;
    mem_req_ready = 1'b0; core_delay = 2;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (des_ready !== 1'b1 || fifo_count !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL b2b_fill[%0d]: des_ready=%b count=%0d, required 1 and %0d",
                 i, des_ready, fifo_count, exp_cnt[i]);
      end
      send_cmd(1'b1, 2'(i % 3), 24'h100 + 24'(i), 24'h200 + 24'(i), 24'h300 + 24'(i), 1'b1);
    end
    n_cmp++;
    if (des_ready !== 1'b0 || fifo_count !== 3'd4) begin
      n_fail++; $display("FAIL b2b_full: des_ready=%b count=%0d, required 0 and 4", des_ready, fifo_count);
    end
    send_cmd(1'b1, 2'd2, 24'hBAD, 24'hBAD, 24'hBAD, 1'b0);
    n_cmp++;
    if (fifo_count !== 3'd4) begin
      n_fail++; $display("FAIL b2b_no_push_full: count=%0d, required 4", fifo_count);
    end
    mem_req_ready = 1'b1;
    for (int i = 0; i < 300 && !(exp_q.size() == 0 && done_cnt == d0 + 5); i++) tick();
    n_cmp++;
    if (done_cnt !== d0 + 5 || exp_q.size() != 0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_retire: cmd_done=%0d pending=%0d count=%0d, required 5 0 0",
               done_cnt - d0, exp_q.size(), fifo_count);
    end
  endtask

  task automatic test_invalid_drop();
    mem_req_ready = 1'b1;
    n_cmp++;
    if (des_ready !== 1'b1) begin
      n_fail++; $display("FAIL drop_ready: des_ready=%b, required 1", des_ready);
    end
    send_cmd(1'b0, 2'd1, 24'h55, 24'h66, 24'h77, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (fifo_count !== 3'd0 || des_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_idle[%0d]: count=%0d ready=%b req=%b, required 0 1 0",
                 i, fifo_count, des_ready, mem_req_valid);
      end
      tick();
    end
  endtask

  task automatic test_reserved();
    int e0, s0, d0;
    e0 = err_cnt; s0 = start_cnt; d0 = done_cnt;
    mem_req_ready = 1'b1; core_delay = 3;
    send_cmd(1'b1, 2'b11, 24'hE1, 24'hE2, 24'hE3, 1'b1);
    tick();
    n_cmp++;
    if (cmd_err !== 1'b1 || mem_req_valid !== 1'b0 || core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reserved_err: err=%b req=%b start=%b, required 1 0 0", cmd_err, mem_req_valid, core_start);
    end
    tick();
    n_cmp++;
    if (cmd_err !== 1'b0 || err_cnt !== e0 + 1) begin
      n_fail++; $display("FAIL reserved_pulse: err=%b pulses=%0d, required 0 and 1", cmd_err, err_cnt - e0);
    end
    send_cmd(1'b1, 2'd2, 24'hA1, 24'hA2, 24'hA3, 1'b1);
    for (int i = 0; i < 100 && !(exp_q.size() == 0 && done_cnt == d0 + 1); i++) tick();
    n_cmp++;
    if (done_cnt !== d0 + 1 || start_cnt !== s0 + 1 || err_cnt !== e0 + 1) begin
      n_fail++;
      $display("FAIL reserved_follow: done=%0d start=%0d err=%0d, required 1 1 1",
               done_cnt - d0, start_cnt - s0, err_cnt - e0);
    end
  endtask

  task automatic test_random_ready();
    int d0;
    d0 = done_cnt; core_delay = 2;
    for (int i = 0; i < 3; i++) begin
      mem_req_ready = 1'($urandom_range(0, 1));
      send_cmd(1'b1, 2'(i), 24'h400 + 24'(i * 7), 24'h500 + 24'(i * 7), 24'h600 + 24'(i * 7), 1'b1);
    end
    for (int i = 0; i < 400 && !(exp_q.size() == 0 && done_cnt == d0 + 3); i++) begin
      mem_req_ready = 1'($urandom_range(0, 1));
      tick();
    end
    mem_req_ready = 1'b1;
    n_cmp++;
    if (done_cnt !== d0 + 3 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_retire: done=%0d pending=%0d, required 3 and 0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int s0, d0;
    s0 = start_cnt; d0 = done_cnt;
    mem_req_ready = 1'b1; core_delay = 40;
    send_cmd(1'b1, 2'd1, 24'h701, 24'h702, 24'h703, 1'b1);
    send_cmd(1'b1, 2'd2, 24'h711, 24'h712, 24'h713, 1'b1);
    send_cmd(1'b1, 2'd1, 24'h721, 24'h722, 24'h723, 1'b1);
    for (int i = 0; i < 50 && start_cnt == s0; i++) tick();
    tick();
    n_cmp++;
    if (start_cnt !== s0 + 1 || fifo_count !== 3'd2) begin
      n_fail++; $display("FAIL mid_wait: starts=%0d count=%0d, required 1 and 2", start_cnt - s0, fifo_count);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({mem_req_valid, core_start, cmd_done, cmd_err, des_ready} !== 5'b0 || fifo_count !== 3'd0 ||
        mem_req_addr !== 24'h0 || core_opcode !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: v=%b st=%b dn=%b er=%b rdy=%b cnt=%0d op=%0d, required all 0",
               mem_req_valid, core_start, cmd_done, cmd_err, des_ready, fifo_count, core_opcode);
    end
    exp_q.delete(); op_q.delete();
    done_timer = 0; core_done = 1'b0; last_type = 2'd3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (des_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_release: des_ready=%b, required 1", des_ready);
    end
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (done_cnt !== d0 || fifo_count !== 3'd0 || start_cnt !== s0 + 1) begin
      n_fail++;
      $display("FAIL mid_abandon: done=%0d count=%0d starts=%0d, required 0 0 1",
               done_cnt - d0, fifo_count, start_cnt - s0);
    end
  endtask

  initial begin
    rst = 1'b1; des_valid_out = 1'b0; des_valid = 1'b0; des_opcode = 2'd0;
    des_key_addr = 24'h0; des_text_addr = 24'h0; des_dest_addr = 24'h0;
    mem_req_ready = 1'b0; core_done = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_invalid_drop();
    test_reserved();
    test_random_ready();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
